fullchip_ctrl: RTL and testbench

Instruction sequencer for the `fullchip` attention core. After a host start, it produces the 19-bit `inst` word cycle by cycle for the whole flow: Q/K memory fill, K preload, execute, ofifo drain to pmem, SFP accumulate/normalize, and pmem readout. It replaces hand-sequenced bench stimulus. It sits between the host/DMA interface and the `fullchip` `inst` port. The host supplies `mem_in` rows in step with `in_ready`.

---
 rtl/fullchip_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_fullchip_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fullchip_ctrl.sv
//------------------------------------------------------------------------------
// Module      : fullchip_ctrl
// Description : Instruction sequencer for the fullchip attention core. Emits
//               the 19-bit inst word for Q/K fill, K preload, execute, ofifo
//               drain, SFP accumulate/normalize and pmem readout.
//               Optional feature macro: FULLCHIP_CTRL_NORM_EN (5-step ACC
//               with divide; undefined gives the 4-step ACC without div).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fullchip_ctrl #(
    parameter int total_cycle = 8,
    parameter int col         = 8,
    parameter int gap         = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [18:0] inst,
    output logic        busy,
    output logic        done,
    output logic [3:0]  phase
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_QWR   = 4'd1,
        S_KWR   = 4'd2,
        S_KLOAD = 4'd3,
        S_GAP1  = 4'd4,
        S_EXEC  = 4'd5,
        S_GAP2  = 4'd6,
        S_OFIFO = 4'd7,
        S_GAP3  = 4'd8,
        S_ACC   = 4'd9,
        S_RDOUT = 4'd10,
        S_DONE  = 4'd11
    } state_t;

    localparam logic [7:0] c_tc_last    = 8'(total_cycle - 1);
    localparam logic [7:0] c_col_last   = 8'(col - 1);
    localparam logic [7:0] c_kload_last = 8'(col + 1);
    localparam logic [7:0] c_col        = 8'(col);
    localparam logic [7:0] c_gap_last   = 8'(gap - 1);
`ifdef FULLCHIP_CTRL_NORM_EN
    localparam logic [2:0] c_acc_s_last = 3'd4;
`else
    localparam logic [2:0] c_acc_s_last = 3'd3;
`endif

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_c;
    logic [7:0] w_c_nxt;
    logic [2:0] r_s;
    logic [2:0] w_s_nxt;

    logic       w_div;
    logic       w_acc;
    logic       w_ofifo_rd;
    logic [3:0] w_qkmem_add;
    logic [3:0] w_pmem_add;
    logic       w_execute;
    logic       w_load;
    logic       w_qmem_rd;
    logic       w_qmem_wr;
    logic       w_kmem_rd;
    logic       w_kmem_wr;
    logic       w_pmem_rd;
    logic       w_pmem_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_c     <= '0;
            r_s     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_c     <= w_c_nxt;
            r_s     <= w_s_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_c_nxt     = r_c;
        w_s_nxt     = r_s;
        w_div       = 1'b0;
        w_acc       = 1'b0;
        w_ofifo_rd  = 1'b0;
        w_qkmem_add = 4'd0;
        w_pmem_add  = 4'd0;
        w_execute   = 1'b0;
        w_load      = 1'b0;
        w_qmem_rd   = 1'b0;
        w_qmem_wr   = 1'b0;
        w_kmem_rd   = 1'b0;
        w_kmem_wr   = 1'b0;
        w_pmem_rd   = 1'b0;
        w_pmem_wr   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_QWR;
            end
            S_QWR: begin
                if (in_valid) begin
                    w_qmem_wr   = 1'b1;
                    w_qkmem_add = r_c[3:0];
                    if (r_c == c_tc_last) w_state_nxt = S_KWR;
                    else                  w_c_nxt     = r_c + 8'd1;
                end
            end
            S_KWR: begin
                if (in_valid) begin
                    w_kmem_wr   = 1'b1;
                    w_qkmem_add = r_c[3:0];
                    if (r_c == c_col_last) w_state_nxt = S_KLOAD;
                    else                   w_c_nxt     = r_c + 8'd1;
                end
            end
            S_KLOAD: begin
                w_load = 1'b1;
                // K rows stream one cycle behind the counter; first and last cycles only hold load
                if (r_c >= 8'd1 && r_c <= c_col) begin
                    w_kmem_rd   = 1'b1;
                    w_qkmem_add = r_c[3:0] - 4'd1;
                end
                if (r_c == c_kload_last) w_state_nxt = (gap == 0) ? S_EXEC : S_GAP1;
                else                     w_c_nxt     = r_c + 8'd1;
            end
            S_GAP1: begin
                if (r_c == c_gap_last) w_state_nxt = S_EXEC;
                else                   w_c_nxt     = r_c + 8'd1;
            end
            S_EXEC: begin
                w_execute   = 1'b1;
                w_qmem_rd   = 1'b1;
                w_qkmem_add = r_c[3:0];
                if (r_c == c_tc_last) w_state_nxt = (gap == 0) ? S_OFIFO : S_GAP2;
                else                  w_c_nxt     = r_c + 8'd1;
            end
            S_GAP2: begin
                if (r_c == c_gap_last) w_state_nxt = S_OFIFO;
                else                   w_c_nxt     = r_c + 8'd1;
            end
            S_OFIFO: begin
                w_ofifo_rd = 1'b1;
                w_pmem_wr  = 1'b1;
                w_pmem_add = r_c[3:0];
                if (r_c == c_tc_last) w_state_nxt = (gap == 0) ? S_ACC : S_GAP3;
                else                  w_c_nxt     = r_c + 8'd1;
            end
            S_GAP3: begin
                if (r_c == c_gap_last) w_state_nxt = S_ACC;
                else                   w_c_nxt     = r_c + 8'd1;
            end
            S_ACC: begin
                w_pmem_add = r_c[3:0];
`ifdef FULLCHIP_CTRL_NORM_EN
                case (r_s)
                    3'd0:    w_pmem_rd = 1'b1;
                    3'd1:    w_acc     = 1'b1;
                    3'd3:    w_div     = 1'b1;
                    3'd4: begin
                        w_div     = 1'b1;
                        w_pmem_wr = 1'b1;
                    end
                    default: ;
                endcase
`else
                case (r_s)
                    3'd0:    w_pmem_rd = 1'b1;
                    3'd1:    w_acc     = 1'b1;
                    3'd3:    w_pmem_wr = 1'b1;
                    default: ;
                endcase
`endif
                if (r_s == c_acc_s_last) begin
                    w_s_nxt = 3'd0;
                    if (r_c == c_tc_last) w_state_nxt = S_RDOUT;
                    else                  w_c_nxt     = r_c + 8'd1;
                end else begin
                    w_s_nxt = r_s + 3'd1;
                end
            end
            S_RDOUT: begin
                w_pmem_rd  = 1'b1;
                w_pmem_add = r_c[3:0];
                if (r_c == c_tc_last) w_state_nxt = S_DONE;
                else                  w_c_nxt     = r_c + 8'd1;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // No state loops onto itself, so any change of state is an entry
        if (w_state_nxt != r_state) begin
            w_c_nxt = 8'd0;
            w_s_nxt = 3'd0;
        end

        if (abort) begin
            w_state_nxt = S_IDLE;
            w_c_nxt     = 8'd0;
            w_s_nxt     = 3'd0;
        end
    end

    assign inst = {w_div, w_acc, w_ofifo_rd, w_qkmem_add, w_pmem_add,
                   w_execute, w_load, w_qmem_rd, w_qmem_wr,
                   w_kmem_rd, w_kmem_wr, w_pmem_rd, w_pmem_wr};

    assign in_ready = (r_state == S_QWR) || (r_state == S_KWR);
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign phase    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_fullchip_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_fullchip_ctrl
// Description : Directed self-checking bench for fullchip_ctrl (default params).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fullchip_ctrl;

    localparam int TC  = 8;
    localparam int COL = 8;
    localparam int GAP = 10;
`ifdef FULLCHIP_CTRL_NORM_EN
    localparam int ACC_STEPS   = 5;
    localparam int EXP_DONE_AT = 121;
    localparam int EXP_DIV     = 16;
`else
    localparam int ACC_STEPS   = 4;
    localparam int EXP_DONE_AT = 113;
    localparam int EXP_DIV     = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [18:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  phase;

    int n_cmp = 0;
    int n_err = 0;

    fullchip_ctrl #(
        .total_cycle (TC),
        .col         (COL),
        .gap         (GAP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .inst     (inst),
        .busy     (busy),
        .done     (done),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected inst/phase for cycle k (1-based) of an unstalled run
    function automatic void model(input int k, output logic [18:0] ei, output logic [3:0] ep,
                                  output logic is_done);
        int t;
        int r;
        int s;
        t = k - 1;
        ei = '0;
        ep = 4'd0;
        is_done = 1'b0;
        if (t < TC) begin
            ep = 4'd1; ei[4] = 1'b1; ei[15:12] = t[3:0]; return;
        end
        t -= TC;
        if (t < COL) begin
            ep = 4'd2; ei[2] = 1'b1; ei[15:12] = t[3:0]; return;
        end
        t -= COL;
        if (t < COL + 2) begin
            ep = 4'd3; ei[6] = 1'b1;
            if (t >= 1 && t <= COL) begin
                r = t - 1;
                ei[3] = 1'b1; ei[15:12] = r[3:0];
            end
            return;
        end
        t -= COL + 2;
        if (t < GAP) begin ep = 4'd4; return; end
        t -= GAP;
        if (t < TC) begin
            ep = 4'd5; ei[7] = 1'b1; ei[5] = 1'b1; ei[15:12] = t[3:0]; return;
        end
        t -= TC;
        if (t < GAP) begin ep = 4'd6; return; end
        t -= GAP;
        if (t < TC) begin
            ep = 4'd7; ei[16] = 1'b1; ei[0] = 1'b1; ei[11:8] = t[3:0]; return;
        end
        t -= TC;
        if (t < GAP) begin ep = 4'd8; return; end
        t -= GAP;
        if (t < TC * ACC_STEPS) begin
            ep = 4'd9;
            r = t / ACC_STEPS;
            s = t % ACC_STEPS;
            ei[11:8] = r[3:0];
            if (s == 0) ei[1] = 1'b1;
            if (s == 1) ei[17] = 1'b1;
`ifdef FULLCHIP_CTRL_NORM_EN
            if (s == 3) ei[18] = 1'b1;
            if (s == 4) begin ei[18] = 1'b1; ei[0] = 1'b1; end
`else
            if (s == 3) ei[0] = 1'b1;
`endif
            return;
        end
        t -= TC * ACC_STEPS;
        if (t < TC) begin
            ep = 4'd10; ei[1] = 1'b1; ei[11:8] = t[3:0]; return;
        end
        t -= TC;
        if (t == 0) is_done = 1'b1;
    endfunction

    // Called at posedge+1 with the DUT idle; ends at posedge+1 in cycle N+1
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    // Full unstalled run with per-cycle comparison against the model
    task automatic run_full(input string name);
        logic [18:0] ei;
        logic [3:0]  ep;
        logic        ed;
        int done_at  = 0;
        int done_n   = 0;
        int ofifo_wr = 0;
        int acc_wr   = 0;
        int div_n    = 0;
        int load_n   = 0;
        int kmrd_n   = 0;
        pulse_start();
        in_valid = 1'b1;
        for (int k = 1; k <= EXP_DONE_AT + 3; k++) begin
            start = (k == 50);
            @(negedge clk);
            model(k, ei, ep, ed);
            chk($sformatf("%s inst k=%0d", name, k), 32'(inst), 32'(ei));
            if (!ed) chk($sformatf("%s phase k=%0d", name, k), 32'(phase), 32'(ep));
            chk($sformatf("%s rdy/busy/done k=%0d", name, k), {29'd0, in_ready, busy, done},
                {29'd0, (k <= TC + COL), (k <= EXP_DONE_AT), ed});
            if (done) begin done_at = k; done_n++; end
            if (inst[0] && inst[16]) ofifo_wr++;
            if (inst[0] && !inst[16]) acc_wr++;
            if (inst[18]) div_n++;
            if (inst[6]) load_n++;
            if (inst[3]) kmrd_n++;
            next_cycle();
        end
        start    = 1'b0;
        in_valid = 1'b0;
        chk({name, " done cycle"}, 32'(done_at), 32'(EXP_DONE_AT));
        chk({name, " done pulses"}, 32'(done_n), 32'd1);
        chk({name, " ofifo pmem_wr"}, 32'(ofifo_wr), 32'd8);
        chk({name, " acc pmem_wr"}, 32'(acc_wr), 32'd8);
        chk({name, " div cycles"}, 32'(div_n), 32'(EXP_DIV));
        chk({name, " load cycles"}, 32'(load_n), 32'd10);
        chk({name, " kmem_rd cycles"}, 32'(kmrd_n), 32'd8);
    endtask

    initial begin
        int wr_n;
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset state", {18'd0, inst, busy, done, phase[3:0]} , 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Idle with start low; in_valid must not cause writes
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            @(negedge clk);
            chk($sformatf("idle k=%0d", k), {6'd0, inst, busy, done, in_ready, phase}, 32'd0);
            next_cycle();
        end
        in_valid = 1'b0;

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        next_cycle();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("start+abort idle", {27'd0, busy, phase}, 32'd0);
        next_cycle();

        run_full("run1");

        // QWR with in_valid toggling 1,0,1,0...
        pulse_start();
        wr_n = 0;
        for (int k = 1; k <= 16; k++) begin
            in_valid = k[0];
            @(negedge clk);
            if (k <= 15) begin
                chk($sformatf("qwr wr k=%0d", k), 32'(inst[4]), 32'(k[0]));
                chk($sformatf("qwr rdy k=%0d", k), 32'(in_ready), 32'd1);
                chk($sformatf("qwr phase k=%0d", k), 32'(phase), 32'd1);
                if (k[0]) chk($sformatf("qwr addr k=%0d", k), 32'(inst[15:12]), 32'((k - 1) / 2));
            end else begin
                chk("qwr->kwr phase", 32'(phase), 32'd2);
            end
            if (inst[4]) wr_n++;
            next_cycle();
        end
        chk("qwr write count", 32'(wr_n), 32'd8);
        in_valid = 1'b0;
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        @(negedge clk);
        chk("abort in kwr", {13'd0, inst, phase[3:0]} , 32'd0);
        next_cycle();

        // Abort mid-EXEC at c=3 (cycle 40 of the run)
        pulse_start();
        in_valid = 1'b1;
        for (int k = 1; k <= 39; k++) next_cycle();
        abort = 1'b1;
        @(negedge clk);
        chk("exec c=3 inst", 32'(inst), 32'h030A0);
        next_cycle();
        abort = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("post-abort k=%0d", k), {6'd0, inst, busy, done, in_ready, phase}, 32'd0);
            next_cycle();
        end

        run_full("run2");

        // Synchronous reset in the middle of a run
        pulse_start();
        in_valid = 1'b1;
        for (int k = 1; k <= 20; k++) next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid-run reset", {6'd0, inst, busy, done, in_ready, phase}, 32'd0);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
